// File: rtl/kb_text_write_controller.sv
// Turns PS/2 scancodes into text RAM writes and owns the cursor.
// Latency: a strobe at edge k starts the write in cycle k+1.
// Backpressure: waits while iVGA_Req is high; a byte arriving while busy is dropped and sets oOverflow.
module kb_text_write_controller #(
    parameter int COLS   = 40,
    parameter int ROWS   = 30,
    parameter int ADDR_W = 11
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic [7:0]        iScan_Data,
    input  logic              iScan_Valid,
    input  logic              iVGA_Req,
    output logic              oWe,
    output logic [ADDR_W-1:0] oAddr,
    output logic [7:0]        oWData,
    output logic [5:0]        oCursor_Col,
    output logic [4:0]        oCursor_Row,
    output logic              oBusy,
    output logic              oOverflow
);

    localparam int                AW1      = ADDR_W + 1;
    localparam logic [5:0]        LAST_COL = 6'(COLS - 1);
    localparam logic [4:0]        LAST_ROW = 5'(ROWS - 1);
    localparam logic [ADDR_W-1:0] CLR_LAST = ADDR_W'(COLS * ROWS - 1);

    typedef enum logic [2:0] {
        IDLE,
        BRK,
        EXT,
        EXT_BRK,
        WRITE,
        CLEAR
    } state_t;

    state_t            state, nState;
    logic [5:0]        col, nCol;
    logic [4:0]        row, nRow;
    logic [ADDR_W-1:0] clrCnt, nClr;
    logic [7:0]        wData, nData;
    logic              advance, nAdv;
    logic              overflow, nOvf;
    logic              busy, we;
    logic [ADDR_W:0]   linAddr;
    logic [5:0]        colInc, colDec;
    logic [4:0]        rowInc, rowDec;

    assign colInc  = (col == LAST_COL) ? 6'd0 : col + 6'd1;
    assign colDec  = (col == 6'd0) ? LAST_COL : col - 6'd1;
    assign rowInc  = (row == LAST_ROW) ? 5'd0 : row + 5'd1;
    assign rowDec  = (row == 5'd0) ? LAST_ROW : row - 5'd1;
    // Computed one bit wider than the RAM address, then truncated at the port.
    assign linAddr = AW1'(row) * AW1'(COLS) + AW1'(col);
    assign busy    = (state == WRITE) || (state == CLEAR);

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state    <= IDLE;
            col      <= 6'd0;
            row      <= 5'd0;
            clrCnt   <= '0;
            wData    <= 8'h00;
            advance  <= 1'b0;
            overflow <= 1'b0;
        end else begin
            state    <= nState;
            col      <= nCol;
            row      <= nRow;
            clrCnt   <= nClr;
            wData    <= nData;
            advance  <= nAdv;
            overflow <= nOvf;
        end
    end

    always_comb begin
        nState = state;
        nCol   = col;
        nRow   = row;
        nClr   = clrCnt;
        nData  = wData;
        nAdv   = advance;
        nOvf   = overflow;
        we     = 1'b0;
        oAddr  = linAddr[ADDR_W-1:0];
        oWData = 8'h00;

        if (iScan_Valid && busy) begin
            nOvf = 1'b1;
        end

        case (state)
            IDLE: begin
                if (iScan_Valid) begin
                    case (iScan_Data)
                        8'hF0: nState = BRK;
                        8'hE0: nState = EXT;
                        8'h5A: begin
                            nCol = 6'd0;
                            nRow = rowInc;
                        end
                        8'h76: begin
                            nCol   = 6'd0;
                            nRow   = 5'd0;
                            nClr   = '0;
                            nState = CLEAR;
                        end
                        8'h66: begin
                            // Backspace steps back linearly but never past the origin.
                            if (col != 6'd0) begin
                                nCol = col - 6'd1;
                            end else if (row != 5'd0) begin
                                nCol = LAST_COL;
                                nRow = row - 5'd1;
                            end
                            nData  = 8'h00;
                            nAdv   = 1'b0;
                            nState = WRITE;
                        end
                        default: begin
                            nData  = iScan_Data;
                            nAdv   = 1'b1;
                            nState = WRITE;
                        end
                    endcase
                end
            end
            BRK, EXT_BRK: begin
                if (iScan_Valid) begin
                    nState = IDLE;
                end
            end
            EXT: begin
                if (iScan_Valid) begin
                    nState = IDLE;
                    case (iScan_Data)
                        8'hF0:   nState = EXT_BRK;
                        8'h75:   nRow = rowDec;
                        8'h72:   nRow = rowInc;
                        8'h6B:   nCol = colDec;
                        8'h74:   nCol = colInc;
                        default: ;
                    endcase
                end
            end
            WRITE: begin
                we     = !iVGA_Req;
                oWData = wData;
                if (we) begin
                    nState = IDLE;
                    if (advance) begin
                        nCol = colInc;
                        if (col == LAST_COL) begin
                            nRow = rowInc;
                        end
                    end
                end
            end
            CLEAR: begin
                we    = !iVGA_Req;
                oAddr = clrCnt;
                if (we) begin
                    if (clrCnt == CLR_LAST) begin
                        nClr   = '0;
                        nState = IDLE;
                    end else begin
                        nClr = clrCnt + 1'b1;
                    end
                end
            end
            default: nState = IDLE;
        endcase
    end

    assign oWe         = we;
    assign oBusy       = busy;
    assign oOverflow   = overflow;
    assign oCursor_Col = col;
    assign oCursor_Row = row;

endmodule

// File: tb/tb_kb_text_write_controller.sv
// Directed bench for kb_text_write_controller: scancode sequences with hand-computed RAM writes and cursor moves.
module tb_kb_text_write_controller;

    logic        Clock = 1'b0;
    logic        Reset = 1'b0;
    logic [7:0]  iScan_Data = 8'h00;
    logic        iScan_Valid = 1'b0;
    logic        iVGA_Req = 1'b0;
    logic        oWe;
    logic [10:0] oAddr;
    logic [7:0]  oWData;
    logic [5:0]  oCursor_Col;
    logic [4:0]  oCursor_Row;
    logic        oBusy;
    logic        oOverflow;

    int checks   = 0;
    int failures = 0;

    kb_text_write_controller #(.COLS(40), .ROWS(30), .ADDR_W(11)) dut (
        .Clock       (Clock),
        .Reset       (Reset),
        .iScan_Data  (iScan_Data),
        .iScan_Valid (iScan_Valid),
        .iVGA_Req    (iVGA_Req),
        .oWe         (oWe),
        .oAddr       (oAddr),
        .oWData      (oWData),
        .oCursor_Col (oCursor_Col),
        .oCursor_Row (oCursor_Row),
        .oBusy       (oBusy),
        .oOverflow   (oOverflow)
    );

    always #5 Clock = ~Clock;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Strobe one byte for a single edge; returns at the negedge of the following cycle.
    task automatic sendByte(input logic [7:0] b);
        @(negedge Clock);
        iScan_Data  = b;
        iScan_Valid = 1'b1;
        @(negedge Clock);
        iScan_Valid = 1'b0;
    endtask

    task automatic checkCursor(input string tag, input int c, input int r);
        checkVal({tag, "_col"}, 32'(oCursor_Col), 32'(c));
        checkVal({tag, "_row"}, 32'(oCursor_Row), 32'(r));
    endtask

    initial begin
        int nWr, cyc, addrErr, dataErr, busyErr, weErr;

        // Reset state
        repeat (3) @(negedge Clock);
        checkVal("rst_we", 32'(oWe), 32'd0);
        checkVal("rst_busy", 32'(oBusy), 32'd0);
        checkVal("rst_wdata", 32'(oWData), 32'h00);
        checkVal("rst_ovf", 32'(oOverflow), 32'd0);
        checkCursor("rst", 0, 0);
        Reset = 1'b1;

        // 1: plain key writes at (0,0) then advances
        sendByte(8'h1C);
        checkVal("t1_we", 32'(oWe), 32'd1);
        checkVal("t1_addr", 32'(oAddr), 32'd0);
        checkVal("t1_data", 32'(oWData), 32'h1C);
        checkVal("t1_busy", 32'(oBusy), 32'd1);
        @(negedge Clock);
        checkVal("t1_we_off", 32'(oWe), 32'd0);
        checkVal("t1_busy_off", 32'(oBusy), 32'd0);
        checkCursor("t1", 1, 0);

        // 2: break and extended-break sequences never write
        sendByte(8'hF0);
        checkVal("t2_brk_we", 32'(oWe), 32'd0);
        sendByte(8'h1C);
        checkVal("t2_brk_we2", 32'(oWe), 32'd0);
        checkCursor("t2_brk", 1, 0);
        sendByte(8'hE0);
        sendByte(8'hF0);
        sendByte(8'h74);
        checkVal("t2_ext_we", 32'(oWe), 32'd0);
        checkVal("t2_ext_busy", 32'(oBusy), 32'd0);
        checkCursor("t2_ext", 1, 0);

        // 3: VGA holds the port for 5 cycles
        @(negedge Clock);
        iVGA_Req    = 1'b1;
        iScan_Data  = 8'h2B;
        iScan_Valid = 1'b1;
        @(negedge Clock);
        iScan_Valid = 1'b0;
        weErr = 0;
        for (int i = 0; i < 5; i++) begin
            if (oWe !== 1'b0 || oBusy !== 1'b1) weErr++;
            @(negedge Clock);
        end
        checkVal("t3_held", 32'(weErr), 32'd0);
        iVGA_Req = 1'b0;
        #1;
        checkVal("t3_we", 32'(oWe), 32'd1);
        checkVal("t3_data", 32'(oWData), 32'h2B);
        checkVal("t3_addr", 32'(oAddr), 32'd1);
        @(negedge Clock);
        checkVal("t3_we_off", 32'(oWe), 32'd0);
        checkCursor("t3", 2, 0);

        // 4: last cell wraps to origin; Enter moves down without writing
        sendByte(8'hE0); sendByte(8'h75);
        sendByte(8'hE0); sendByte(8'h6B);
        sendByte(8'hE0); sendByte(8'h6B);
        sendByte(8'hE0); sendByte(8'h6B);
        checkCursor("t4_pos", 39, 29);
        sendByte(8'h16);
        checkVal("t4_we", 32'(oWe), 32'd1);
        checkVal("t4_addr", 32'(oAddr), 32'd1199);
        checkVal("t4_data", 32'(oWData), 32'h16);
        @(negedge Clock);
        checkCursor("t4_wrap", 0, 0);
        sendByte(8'h5A);
        checkVal("t4_enter_we", 32'(oWe), 32'd0);
        checkVal("t4_enter_busy", 32'(oBusy), 32'd0);
        checkCursor("t4_enter", 0, 1);

        // 5: left arrow wraps within row; backspace at origin writes 00 at 0
        sendByte(8'hE0); sendByte(8'h75);
        checkCursor("t5_up", 0, 0);
        sendByte(8'hE0); sendByte(8'h6B);
        checkVal("t5_left_we", 32'(oWe), 32'd0);
        checkCursor("t5_left", 39, 0);
        sendByte(8'hE0); sendByte(8'h74);
        checkCursor("t5_right", 0, 0);
        sendByte(8'h66);
        checkVal("t5_bs_we", 32'(oWe), 32'd1);
        checkVal("t5_bs_addr", 32'(oAddr), 32'd0);
        checkVal("t5_bs_data", 32'(oWData), 32'h00);
        @(negedge Clock);
        checkCursor("t5_bs", 0, 0);

        // 6: clear with VGA contention and a dropped strobe
        checkVal("t6_ovf_pre", 32'(oOverflow), 32'd0);
        sendByte(8'h76);
        nWr = 0; cyc = 0; addrErr = 0; dataErr = 0; busyErr = 0; weErr = 0;
        while (nWr < 1200 && cyc < 5000) begin
            iVGA_Req    = cyc[0];
            iScan_Valid = (cyc == 100);
            iScan_Data  = 8'h1C;
            #1;
            if (oBusy !== 1'b1) busyErr++;
            if (oWe === 1'b1 && iVGA_Req) weErr++;
            if (oWe === 1'b1) begin
                if (oAddr !== 11'(nWr)) addrErr++;
                if (oWData !== 8'h00) dataErr++;
                nWr++;
            end
            cyc++;
            @(negedge Clock);
        end
        iVGA_Req    = 1'b0;
        iScan_Valid = 1'b0;
        checkVal("t6_writes", 32'(nWr), 32'd1200);
        checkVal("t6_addr_err", 32'(addrErr), 32'd0);
        checkVal("t6_data_err", 32'(dataErr), 32'd0);
        checkVal("t6_busy_err", 32'(busyErr), 32'd0);
        checkVal("t6_we_vs_req", 32'(weErr), 32'd0);
        checkVal("t6_busy_end", 32'(oBusy), 32'd0);
        checkVal("t6_ovf", 32'(oOverflow), 32'd1);
        checkCursor("t6_end", 0, 0);

        // Reset in the middle of a clear
        sendByte(8'h1C);
        @(negedge Clock);
        checkCursor("t6_pre_esc", 1, 0);
        sendByte(8'h76);
        repeat (10) @(negedge Clock);
        checkVal("t6_mid_busy", 32'(oBusy), 32'd1);
        Reset = 1'b0;
        @(negedge Clock);
        Reset = 1'b1;
        checkVal("t6_rst_busy", 32'(oBusy), 32'd0);
        checkVal("t6_rst_we", 32'(oWe), 32'd0);
        checkVal("t6_rst_ovf", 32'(oOverflow), 32'd0);
        checkCursor("t6_rst", 0, 0);
        sendByte(8'h3A);
        checkVal("t6_post_we", 32'(oWe), 32'd1);
        checkVal("t6_post_addr", 32'(oAddr), 32'd0);
        @(negedge Clock);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/kb_text_write_controller.md
Name: kb_text_write_controller

Overview:
Sequences PS/2 keyboard scancodes into the VGA text buffer RAM and owns the cursor position. It consumes decoded scancode bytes from the PS/2 receiver and interprets make, break (F0) and extended (E0) prefixes. It issues single-cycle writes to the shared text RAM port, always yielding to the VGA reader. The VGA character path reads raw scancodes from the buffer, so no ASCII translation is done here.

Parameters:
COLS, 40, text columns per row
ROWS, 30, text rows
ADDR_W, 11, text RAM address width; must satisfy COLS*ROWS <= 2^ADDR_W

Ports:
Clock  in  1  system clock; all logic on rising edge
Reset  in  1  synchronous, active-low reset
iScan_Data  in  8  scancode byte from PS/2 receiver
iScan_Valid  in  1  one-cycle strobe; iScan_Data valid
iVGA_Req  in  1  VGA reader owns the RAM port this cycle (priority)
oWe  out  1  text RAM write enable
oAddr  out  ADDR_W  text RAM write address
oWData  out  8  text RAM write data
oCursor_Col  out  6  cursor column, 0..COLS-1
oCursor_Row  out  5  cursor row, 0..ROWS-1
oBusy  out  1  high in WRITE or CLEAR
oOverflow  out  1  sticky: a scancode was dropped while busy

Behaviour:
- Reset (Reset=0 at an edge): state IDLE, cursor (0,0), clear counter 0, oOverflow 0. oWe=0, oBusy=0, oWData=0x00. Reset overrides everything, including mid-CLEAR or mid-WRITE; a partially cleared RAM is acceptable.
- States: IDLE, BRK, EXT, EXT_BRK, WRITE, CLEAR.
- IDLE, byte accepted on iScan_Valid:
  - F0 -> BRK.
  - E0 -> EXT.
  - 5A (Enter) -> col=0, row=row+1 mod ROWS; no write; stay IDLE.
  - 76 (Esc) -> cursor (0,0), clear counter 0, -> CLEAR.
  - 66 (Backspace) -> cursor decrements linearly (col 0 -> col COLS-1 of row-1; at (0,0) stays (0,0)). Latch data 0x00 with advance=0, -> WRITE.
  - Any other byte -> latch byte with advance=1, -> WRITE.
- BRK: the next valid byte is discarded -> IDLE.
- EXT: on the next valid byte:
  - F0 -> EXT_BRK.
  - 75 -> row-1 mod ROWS.
  - 72 -> row+1 mod ROWS.
  - 6B -> col-1 mod COLS.
  - 74 -> col+1 mod COLS.
  - All other bytes are ignored.
  - Every case except F0 -> IDLE. Arrow moves wrap within the same row/column.
- EXT_BRK: the next valid byte is discarded -> IDLE.
- WRITE:
  - oWe = !iVGA_Req (combinational). oAddr = row*COLS+col, truncated to ADDR_W. oWData = latched byte.
  - On the edge where oWe=1: if advance, col+1; at col COLS-1, col=0 and row+1 mod ROWS. Then -> IDLE.
  - While iVGA_Req=1, the write is held with no timeout.
- CLEAR:
  - oWe = !iVGA_Req. oAddr = clear counter. oWData = 0x00.
  - Counter increments only on edges with oWe=1.
  - After writing address COLS*ROWS-1 -> IDLE, counter reset to 0.
- Latency: scancode strobe at edge k -> WRITE from cycle k+1 -> oWe high in cycle k+1 if iVGA_Req=0.
- Overflow: iScan_Valid while oBusy=1 drops the byte, sets oOverflow=1, and leaves state unchanged.
- Address arithmetic: row*COLS+col is computed in ADDR_W+1 bits, then truncated.
- Cursor outputs are registered and change only on the edge that commits a move or write.
- oWe is never high in IDLE, BRK, EXT or EXT_BRK.

Test Plan:
1. Reset, iVGA_Req=0, send 1C -> one-cycle oWe, oAddr=0, oWData=1C; cursor then (col 1, row 0); oBusy back to 0.
2. Send F0,1C -> no oWe, cursor unchanged. Send E0,F0,74 -> no oWe, cursor unchanged.
3. Hold iVGA_Req=1 for 5 cycles across a 2B strobe -> oWe stays 0 for 5 cycles, then fires the cycle after iVGA_Req drops, oWData=2B.
4. Cursor (39,29), send 16 -> oAddr=1199, cursor wraps to (0,0). Then send 5A -> cursor (0,1), no write.
5. At (0,0): E0,6B -> cursor (39,0), no write. Back at (0,0), send 66 -> cursor stays (0,0), write 00 to address 0.
6. Send 76 with iVGA_Req toggling every other cycle -> exactly 1200 writes, addresses 0..1199 ascending, all data 00, oBusy high throughout. A strobe during CLEAR sets oOverflow=1. Reset mid-CLEAR returns to IDLE with cursor (0,0).
